// File: rtl/agc_io_pkg.sv
// Shared types and constants for the AGC serial I/O bank.
package agc_io_pkg;
  localparam int AGC_WORD_W = 15;
  localparam int FRAME_BITS = AGC_WORD_W + 2;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Status/clear register sits right after the input and output word slots.
  function automatic int status_sel(input int num_in, input int num_out);
    return num_in + num_out;
  endfunction
endpackage

// File: rtl/agc_serial_rx.sv
// One serial receiver: 2-flop synchroniser, mid-bit sampling FSM, word shifter.
module agc_serial_rx
  import agc_io_pkg::*;
#(
  parameter int WORD_W  = AGC_WORD_W,
  parameter int CLK_DIV = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              line,
  output logic [WORD_W-1:0] word,
  output logic              commit,
  output logic              error
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);

  rx_state_t         st;
  logic [1:0]        sync;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bits;
  logic [WORD_W-1:0] shreg;
  logic              ln, tick;

  assign ln   = sync[1];
  assign tick = cnt == LAST;

  always_ff @(posedge clock) begin
    if (reset) begin
      st    <= RX_IDLE;
      sync  <= 2'b11;
      cnt   <= '0;
      bits  <= '0;
      shreg <= '0;
    end else begin
      sync <= {sync[0], line};
      case (st)
        RX_IDLE: begin
          cnt <= '0;
          if (!ln) st <= RX_START;
        end
        // Half-bit wait lands every later sample in the middle of its bit.
        RX_START: begin
          cnt <= cnt + 1'b1;
          if (cnt == HALF) begin
            cnt  <= '0;
            bits <= '0;
            st   <= ln ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            shreg <= {ln, shreg[WORD_W-1:1]};
            bits  <= bits + 1'b1;
            if (bits == BW'(WORD_W - 1)) st <= RX_STOP;
          end
        end
        RX_STOP: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) st <= ln ? RX_IDLE : RX_BREAK;
        end
        RX_BREAK: if (ln) st <= RX_IDLE;
        default:  st <= RX_IDLE;
      endcase
    end
  end

  assign word   = shreg;
  assign commit = (st == RX_STOP) && tick && ln;
  assign error  = (st == RX_STOP) && tick && !ln;
endmodule

// File: rtl/agc_serial_io_bank.sv
// Bank of serial receivers/transmitters behind the core's select/read/write port.
module agc_serial_io_bank
  import agc_io_pkg::*;
#(
  parameter int WORD_W  = AGC_WORD_W,
  parameter int NUM_IN  = 6,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = 5,
  parameter int CLK_DIV = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [SEL_W-1:0]   sel_read,
  output logic [WORD_W-1:0]  data_read,
  input  logic [SEL_W-1:0]   sel_write,
  input  logic               en_write,
  input  logic [WORD_W-1:0]  data_write,
  input  logic [NUM_IN-1:0]  ser_in,
  output logic [NUM_OUT-1:0] ser_out,
  output logic [NUM_IN-1:0]  rx_err,
  output logic [NUM_OUT-1:0] tx_busy
);
  localparam int STAT = status_sel(NUM_IN, NUM_OUT);
  localparam int CW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [NUM_IN-1:0][WORD_W-1:0]  in_word, rx_word;
  logic [NUM_OUT-1:0][WORD_W-1:0] out_word;
  logic [NUM_IN-1:0]              rx_commit, rx_error, fresh;
  logic                           status_wr;

  assign status_wr = en_write && (sel_write == SEL_W'(STAT));

  for (genvar i = 0; i < NUM_IN; i++) begin : g_rx
    agc_serial_rx #(.WORD_W(WORD_W), .CLK_DIV(CLK_DIV)) u_rx (
      .clock  (clock),
      .reset  (reset),
      .line   (ser_in[i]),
      .word   (rx_word[i]),
      .commit (rx_commit[i]),
      .error  (rx_error[i])
    );
  end

  // A commit beats a read-clear, and a new error beats a status clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_word <= '0;
      fresh   <= '0;
      rx_err  <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (rx_commit[i]) begin
          in_word[i] <= rx_word[i];
          fresh[i]   <= 1'b1;
        end else if (sel_read == SEL_W'(i)) begin
          fresh[i] <= 1'b0;
        end
        if (rx_error[i])                       rx_err[i] <= 1'b1;
        else if (status_wr && data_write[i])   rx_err[i] <= 1'b0;
      end
    end
  end

  always_comb begin
    data_read = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (sel_read == SEL_W'(i)) data_read = in_word[i];
    for (int j = 0; j < NUM_OUT; j++)
      if (sel_read == SEL_W'(NUM_IN + j)) data_read = out_word[j];
    if (sel_read == SEL_W'(STAT)) data_read = WORD_W'(fresh);
  end

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_tx
    tx_state_t         st;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bits;
    logic [WORD_W-1:0] shreg, pend, word;
    logic              pend_vld, line, wr, tick;

    assign wr   = en_write && (sel_write == SEL_W'(NUM_IN + j));
    assign tick = cnt == LAST;

    always_ff @(posedge clock) begin
      if (reset) begin
        st       <= TX_IDLE;
        cnt      <= '0;
        bits     <= '0;
        shreg    <= '0;
        pend     <= '0;
        pend_vld <= 1'b0;
        word     <= '0;
        line     <= 1'b1;
      end else begin
        if (wr) word <= data_write;
        cnt <= (st == TX_IDLE || tick) ? '0 : cnt + 1'b1;
        case (st)
          TX_IDLE: if (wr) begin
            st    <= TX_START;
            line  <= 1'b0;
            shreg <= data_write;
          end
          TX_START: if (tick) begin
            st    <= TX_DATA;
            line  <= shreg[0];
            shreg <= shreg >> 1;
            bits  <= '0;
          end
          TX_DATA: if (tick) begin
            if (bits == BW'(WORD_W - 1)) begin
              st   <= TX_STOP;
              line <= 1'b1;
            end else begin
              line  <= shreg[0];
              shreg <= shreg >> 1;
              bits  <= bits + 1'b1;
            end
          end
          TX_STOP: if (tick) begin
            if (pend_vld) begin
              st       <= TX_START;
              line     <= 1'b0;
              shreg    <= pend;
              pend_vld <= 1'b0;
            end else if (wr) begin
              st    <= TX_START;
              line  <= 1'b0;
              shreg <= data_write;
            end else begin
              st <= TX_IDLE;
            end
          end
          default: st <= TX_IDLE;
        endcase
        // Busy writes park here; placed last so a write on the cycle the
        // pending word is launched re-arms the pending slot.
        if (wr && st != TX_IDLE && !(st == TX_STOP && tick && !pend_vld)) begin
          pend     <= data_write;
          pend_vld <= 1'b1;
        end
      end
    end

    assign out_word[j] = word;
    assign ser_out[j]  = line;
    assign tx_busy[j]  = (st != TX_IDLE) || pend_vld;
  end
endmodule
